// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128 key-schedule engine.
// Loads a 128-bit cipher key and hands out round keys 0..10 over a
// valid/ready interface, one per handshake, in order.
// Optional feature macro: AES_KEYEXP_STORE_EN adds an 11-entry round-key
// store with a combinational read port (rd_addr/rd_key). Without it,
// rd_key is tied to zero.
module aes_key_expand_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // FIPS-197 forward S-box
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] i_b);
        return SBOX[i_b];
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_load;
    logic         w_advance;
    logic         w_done_next;
    logic         w_handshake;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon_next;

    // Next-key arithmetic: RotWord, four S-boxes, Rcon, then the word-chain XOR
    assign w_w0  = r_round_key[127:96];
    assign w_w1  = r_round_key[95:64];
    assign w_w2  = r_round_key[63:32];
    assign w_w3  = r_round_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                    f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])};
    assign w_t   = w_sub ^ {r_rcon, 24'h0};
    assign w_n0  = w_w0 ^ w_t;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign w_next_key  = {w_n0, w_n1, w_n2, w_n3};
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    assign w_handshake = (r_state == ST_RUN) && rk_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: start only counts in IDLE, ready only counts in RUN
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rk_ready) begin
                    if (r_round_idx == 4'd10) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Round-key, index and rcon registers; they hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round_key <= '0;
            r_round_idx <= '0;
            r_rcon      <= 8'h01;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_load) begin
                r_round_key <= key_in;
                r_round_idx <= 4'd0;
                r_rcon      <= 8'h01;
            end else if (w_advance) begin
                r_round_key <= w_next_key;
                r_round_idx <= r_round_idx + 4'd1;
                r_rcon      <= w_rcon_next;
            end
        end
    end

    assign rk_valid  = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign round_key = r_round_key;
    assign round_idx = r_round_idx;

`ifdef AES_KEYEXP_STORE_EN
    logic [127:0] r_store [0:10];

    // Capture each accepted round key at its index for later (e.g. reverse) reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_handshake) begin
            r_store[r_round_idx] <= r_round_key;
        end
    end

    assign rd_key = (rd_addr <= 4'd10) ? r_store[rd_addr] : '0;
`else
    logic w_unused_inputs;
    assign w_unused_inputs = (^rd_addr) ^ w_handshake;
    assign rd_key = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed test of the AES-128 key-schedule engine
// using FIPS-197 round keys and a few hand-checked vectors.
module tb_aes_key_expand_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] keyIn;
    logic         rkValid;
    logic         rkReady;
    logic [127:0] roundKey;
    logic [3:0]   roundIdx;
    logic         busy;
    logic         done;
    logic [3:0]   rdAddr;
    logic [127:0] rdKey;

    int total;
    int bad;

    logic [127:0] fipsKeys [0:10];
    logic [127:0] fipsKey;
    logic [127:0] seqKey;
    logic [3:0]   readyPat;
    logic         readyNow;
    logic         finished;
    int           expIdx;

    aes_key_expand_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (keyIn),
        .rk_valid  (rkValid),
        .rk_ready  (rkReady),
        .round_key (roundKey),
        .round_idx (roundIdx),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rdAddr),
        .rd_key    (rdKey)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the coming rising edge, then move 1 ns past it
    task automatic applyStimulus(input logic iStart, input logic [127:0] iKey, input logic iReady);
        start   = iStart;
        keyIn   = iKey;
        rkReady = iReady;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and count and report it if it fails
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        fipsKey     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        seqKey      = 128'h000102030405060708090a0b0c0d0e0f;
        fipsKeys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fipsKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fipsKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fipsKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fipsKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fipsKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fipsKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fipsKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fipsKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fipsKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fipsKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset values
        rst_n   = 1'b0;
        start   = 1'b0;
        keyIn   = '0;
        rkReady = 1'b0;
        rdAddr  = 4'd0;
        #12;
        checkOutput("rst_valid", 128'(rkValid), 128'd0);
        checkOutput("rst_busy",  128'(busy),    128'd0);
        checkOutput("rst_done",  128'(done),    128'd0);
        checkOutput("rst_key",   roundKey,      128'd0);
        checkOutput("rst_idx",   128'(roundIdx), 128'd0);
        rst_n = 1'b1;

        // FIPS-197 key, consumer always ready: 11 consecutive round keys
        applyStimulus(1'b1, fipsKey, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            checkOutput($sformatf("t1_valid%0d", i), 128'(rkValid), 128'd1);
            checkOutput($sformatf("t1_idx%0d", i), 128'(roundIdx), 128'(i));
            checkOutput($sformatf("t1_key%0d", i), roundKey, fipsKeys[i]);
            checkOutput($sformatf("t1_done%0d", i), 128'(done), 128'd0);
            applyStimulus(1'b0, fipsKey, 1'b1);
        end
        checkOutput("t1_done_pulse", 128'(done),    128'd1);
        checkOutput("t1_valid_fall", 128'(rkValid), 128'd0);
        checkOutput("t1_busy_fall",  128'(busy),    128'd0);
        applyStimulus(1'b0, fipsKey, 1'b1);
        checkOutput("t1_done_clear", 128'(done),    128'd0);
        checkOutput("t1_idle_ready", 128'(rkValid), 128'd0);

`ifdef AES_KEYEXP_STORE_EN
        rdAddr = 4'd10;
        #1;
        checkOutput("st_rd10", rdKey, fipsKeys[10]);
        rdAddr = 4'd0;
        #1;
        checkOutput("st_rd0", rdKey, fipsKeys[0]);
        rdAddr = 4'd5;
        #1;
        checkOutput("st_rd5", rdKey, fipsKeys[5]);
        rdAddr = 4'd15;
        #1;
        checkOutput("st_rd15", rdKey, 128'd0);
`else
        for (int a = 0; a < 16; a += 5) begin
            rdAddr = 4'(a);
            #1;
            checkOutput($sformatf("nost_rd%0d", a), rdKey, 128'd0);
        end
`endif
        rdAddr = 4'd0;

        // Same key with ready toggling 1,0,0,1: stable through stalls
        readyPat = 4'b1001;
        finished = 1'b0;
        expIdx   = 0;
        applyStimulus(1'b1, fipsKey, 1'b1);
        for (int c = 0; c < 60 && !finished; c++) begin
            readyNow = readyPat[3 - (c % 4)];
            checkOutput($sformatf("t2_key_c%0d", c), roundKey, fipsKeys[expIdx]);
            checkOutput($sformatf("t2_idx_c%0d", c), 128'(roundIdx), 128'(expIdx));
            checkOutput($sformatf("t2_busy_c%0d", c), 128'(busy), 128'd1);
            applyStimulus(1'b0, fipsKey, readyNow);
            if (readyNow) begin
                if (expIdx == 10) finished = 1'b1;
                else expIdx++;
            end
        end
        checkOutput("t2_finished", 128'(finished), 128'd1);
        checkOutput("t2_done",     128'(done),     128'd1);
        checkOutput("t2_busy_end", 128'(busy),     128'd0);

        // Start during RUN ignored; start on final handshake ignored
        applyStimulus(1'b1, fipsKey, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            checkOutput($sformatf("t3_key%0d", i), roundKey, fipsKeys[i]);
            checkOutput($sformatf("t3_idx%0d", i), 128'(roundIdx), 128'(i));
            if (i == 4)       applyStimulus(1'b1, {128{1'b1}}, 1'b1);
            else if (i == 10) applyStimulus(1'b1, seqKey, 1'b1);
            else              applyStimulus(1'b0, fipsKey, 1'b1);
        end
        checkOutput("t3_done",       128'(done),    128'd1);
        checkOutput("t3_final_idle", 128'(rkValid), 128'd0);
        applyStimulus(1'b1, seqKey, 1'b1);
        checkOutput("t3_restart_valid", 128'(rkValid), 128'd1);
        checkOutput("t3_restart_idx",   128'(roundIdx), 128'd0);
        checkOutput("t3_restart_key",   roundKey, seqKey);

        // Reset at round 6 mid-operation
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, seqKey, 1'b1);
        checkOutput("t4_idx6", 128'(roundIdx), 128'd6);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_valid", 128'(rkValid),  128'd0);
        checkOutput("t4_rst_busy",  128'(busy),     128'd0);
        checkOutput("t4_rst_done",  128'(done),     128'd0);
        checkOutput("t4_rst_key",   roundKey,       128'd0);
        checkOutput("t4_rst_idx",   128'(roundIdx), 128'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, seqKey, 1'b1);
        checkOutput("t4_no_done", 128'(done), 128'd0);
        applyStimulus(1'b1, seqKey, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, seqKey, 1'b1);
        checkOutput("t4_idx10", 128'(roundIdx), 128'd10);
        checkOutput("t4_key10", roundKey, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        applyStimulus(1'b0, seqKey, 1'b1);
        checkOutput("t4_done", 128'(done), 128'd1);

        // All-zero key: S-box(00)=63 and Rcon 01
        applyStimulus(1'b1, 128'd0, 1'b1);
        checkOutput("t5_key0", roundKey, 128'd0);
        applyStimulus(1'b0, 128'd0, 1'b1);
        checkOutput("t5_idx1", 128'(roundIdx), 128'd1);
        checkOutput("t5_key1", roundKey, 128'h62636363626363636263636362636363);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 128'd0, 1'b1);
        checkOutput("t5_done", 128'(done), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
